// File: rtl/wr_arb_pkg.sv
// Shared types and helpers for the write-data arbiter family.
// Used by wr_data_arbiter and rr_pick.
package wr_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam logic ARB_MODE_RR    = 1'b0;
    localparam logic ARB_MODE_FIXED = 1'b1;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: round-robin from ptr, or fixed priority with
// channel 0 highest. The found flag is low when no channel is valid.
module rr_pick
    import wr_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] valid,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              mode,
    output logic              found,
    output logic [SEL_W-1:0]  index
);

    always_comb begin
        int               cand;
        logic [SEL_W-1:0] cand_sel;
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        found    = 1'b0;
        index    = '0;
        cand     = 0;
        cand_sel = '0;
        // Walk from the lowest search offset last so the closest candidate wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand     = (mode == ARB_MODE_FIXED) ? k : (int'(ptr) + k) % NUM_CH;
            cand_sel = SEL_W'(cand);
            if (valid[cand_sel]) begin
                found = 1'b1;
                index = cand_sel;
            end
        end
    end

endmodule

// File: rtl/wr_data_arbiter.sv
// N-channel write-data arbiter with burst-locked grants feeding one write FIFO.
// Define WR_ARB_STATS_EN to add the grant / stall statistics counters.
module wr_data_arbiter
    import wr_arb_pkg::*;
#(
    parameter int  NUM_CH    = 4,
    parameter int  DATA_W    = 32,
    parameter int  BURST_MAX = 8,
    localparam int SEL_W     = sel_width(NUM_CH)
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     arb_mode,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH-1:0]        ch_last,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic                     fifo_afull,
    output logic                     fifo_push_n,
    output logic [DATA_W-1:0]        fifo_data,
    output logic [SEL_W-1:0]         grant_ch,
    output logic                     busy
`ifdef WR_ARB_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]     stat_grants,
    output logic [15:0]              stat_stall_cycles
`endif
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arb_state_t       state, state_d;
    logic [SEL_W-1:0] rr_ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic [DATA_W-1:0] ch_word [NUM_CH];
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             xfer;
    logic             burst_end;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_word[i] = ch_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_pick (
        .valid (ch_valid),
        .ptr   (rr_ptr),
        .mode  (arb_mode),
        .found (pick_found),
        .index (pick_idx)
    );

    assign busy = (state == ARB_BURST);

    always_comb begin
        state_d   = state;
        ch_ready  = '0;
        xfer      = 1'b0;
        burst_end = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_found) state_d = ARB_BURST;
            end
            ARB_BURST: begin
                // Ready drops combinationally with afull so at most one beat is ever in flight.
                ch_ready[grant_ch] = !fifo_afull;
                xfer      = ch_valid[grant_ch] && !fifo_afull;
                burst_end = xfer && (ch_last[grant_ch] || beat_cnt == CNT_W'(BURST_MAX - 1));
                if (burst_end) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            grant_ch    <= '0;
            fifo_push_n <= 1'b1;
            fifo_data   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            state       <= state_d;
            fifo_push_n <= !xfer;
            if (xfer) fifo_data <= ch_word[grant_ch];
            if (state == ARB_IDLE && pick_found) grant_ch <= pick_idx;
            if (burst_end) begin
                beat_cnt <= '0;
                rr_ptr   <= (grant_ch == SEL_W'(NUM_CH - 1)) ? '0 : grant_ch + SEL_W'(1);
            end else if (xfer) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

`ifdef WR_ARB_STATS_EN
    logic [15:0] grant_cnt [NUM_CH];
    logic [15:0] stall_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // NOTE: the counter array is a handful of flops, so it is reset like any other register.
            for (int i = 0; i < NUM_CH; i++) grant_cnt[i] <= '0;
            stall_cnt <= '0;
        end else begin
            if (state == ARB_IDLE && pick_found && grant_cnt[pick_idx] != 16'hFFFF)
                grant_cnt[pick_idx] <= grant_cnt[pick_idx] + 16'd1;
            if (state == ARB_BURST && fifo_afull && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_stat
        assign stat_grants[i*16 +: 16] = grant_cnt[i];
    end
    assign stat_stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_wr_data_arbiter.sv
// Self-checking bench for wr_data_arbiter: per-channel source queues feed the DUT and
// an expected-push queue is compared against every FIFO push.
module tb_wr_data_arbiter;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 32;
    localparam int BURST_MAX = 8;
    localparam int SEL_W     = 2;

    logic                     sys_clk;
    logic                     sys_rst_n;
    logic                     arb_mode;
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH-1:0]        ch_last;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_ready;
    logic                     fifo_afull;
    logic                     fifo_push_n;
    logic [DATA_W-1:0]        fifo_data;
    logic [SEL_W-1:0]         grant_ch;
    logic                     busy;
`ifdef WR_ARB_STATS_EN
    logic [NUM_CH*16-1:0]     stat_grants;
    logic [15:0]              stat_stall_cycles;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t             src_q [NUM_CH][$];
    logic [DATA_W-1:0] exp_q [$];
    int                checks   = 0;
    int                failures = 0;
    logic              pend     = 1'b0;
    logic [NUM_CH-1:0] last_acc = '0;
    int                acc_total = 0;

    wr_data_arbiter #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rst_n         (sys_rst_n),
        .arb_mode          (arb_mode),
        .ch_valid          (ch_valid),
        .ch_last           (ch_last),
        .ch_data           (ch_data),
        .ch_ready          (ch_ready),
        .fifo_afull        (fifo_afull),
        .fifo_push_n       (fifo_push_n),
        .fifo_data         (fifo_data),
        .grant_ch          (grant_ch),
        .busy              (busy)
`ifdef WR_ARB_STATS_EN
        ,
        .stat_grants       (stat_grants),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input int ch, input int seq);
        return {8'(ch), 8'h00, 16'(seq)};
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NUM_CH; i++)
            if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add_beat(input int ch, input logic [DATA_W-1:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        src_q[ch].push_back(b);
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_CH; i++) begin
            if (src_q[i].size() > 0) begin
                ch_valid[i]                  = 1'b1;
                ch_last[i]                   = src_q[i][0].last;
                ch_data[i*DATA_W +: DATA_W]  = src_q[i][0].data;
            end else begin
                ch_valid[i]                  = 1'b0;
                ch_last[i]                   = 1'b0;
                ch_data[i*DATA_W +: DATA_W]  = '0;
            end
        end
    endtask

    // One clock: monitor at the negedge, advance sources just after the posedge.
    task automatic cycle();
        @(negedge sys_clk);
        if (!fifo_push_n) begin
            if (exp_q.size() > 0) check("push_data", 64'(fifo_data), 64'(exp_q.pop_front()));
            else                  check("unexpected_push", 64'(fifo_push_n), 64'(1));
        end
        check("push_latency", 64'(fifo_push_n), 64'(!pend));
        check("ready_onehot", 64'($onehot0(ch_ready)), 64'(1));
        if (fifo_afull) check("ready_afull", 64'(ch_ready), 64'(0));
        last_acc = ch_valid & ch_ready;
        pend     = |last_acc;
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (last_acc[i]) begin
                void'(src_q[i].pop_front());
                acc_total++;
            end
        end
        drive();
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n = 0;
        while ((busy || pend || !all_empty() || exp_q.size() > 0) && n < max_cycles) begin
            cycle();
            n++;
        end
        check({tag, "_drained"}, 64'(n < max_cycles), 64'(1));
    endtask

    task automatic clear_bench();
        for (int i = 0; i < NUM_CH; i++) src_q[i].delete();
        exp_q.delete();
        pend       = 1'b0;
        fifo_afull = 1'b0;
        drive();
    endtask

    initial begin
        int n;
        int acc_before;
        sys_rst_n  = 1'b0;
        arb_mode   = 1'b0;
        fifo_afull = 1'b0;
        ch_valid   = '0;
        ch_last    = '0;
        ch_data    = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_busy",      64'(busy),        64'(0));
        check("rst_push_n",    64'(fifo_push_n), 64'(1));
        check("rst_ready",     64'(ch_ready),    64'(0));
        check("rst_grant",     64'(grant_ch),    64'(0));
        check("rst_fifo_data", 64'(fifo_data),   64'(0));
        sys_rst_n = 1'b1;

        // Reset mid-burst: ch0 streams, reset after the third accept.
        for (int s = 0; s < 6; s++) begin
            add_beat(0, 32'h0000_1000 + 32'(s), 1'b0);
            exp_q.push_back(32'h0000_1000 + 32'(s));
        end
        drive();
        acc_total = 0;
        n = 0;
        while (acc_total < 3 && n < 50) begin
            cycle();
            n++;
        end
        check("t1_three_accepts", 64'(acc_total), 64'(3));
        check("t1_busy_before", 64'(busy), 64'(1));
        check("t1_pushes_before_reset", 64'(exp_q.size()), 64'(4));
        sys_rst_n = 1'b0;
        #1;
        check("t1_rst_busy",   64'(busy),        64'(0));
        check("t1_rst_push_n", 64'(fifo_push_n), 64'(1));
        check("t1_rst_ready",  64'(ch_ready),    64'(0));
        clear_bench();
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        add_beat(0, mk(0, 16'h2000), 1'b1);
        add_beat(3, mk(3, 16'h2000), 1'b1);
        exp_q.push_back(mk(0, 16'h2000));
        exp_q.push_back(mk(3, 16'h2000));
        drive();
        cycle();
        check("t1_regrant_busy", 64'(busy),     64'(1));
        check("t1_regrant_ch0",  64'(grant_ch), 64'(0));
        drain("t1", 50);

        // Round-robin with all channels valid and single-beat bursts: 0,1,2,3,0.
        add_beat(0, mk(0, 0), 1'b1);
        add_beat(0, mk(0, 1), 1'b1);
        for (int c = 1; c < NUM_CH; c++) add_beat(c, mk(c, 0), 1'b1);
        exp_q.push_back(mk(0, 0));
        exp_q.push_back(mk(1, 0));
        exp_q.push_back(mk(2, 0));
        exp_q.push_back(mk(3, 0));
        exp_q.push_back(mk(0, 1));
        drive();
        drain("t2", 60);

        // Fixed priority: ch1 wins while valid, ch3 only afterwards.
        arb_mode = 1'b1;
        for (int s = 0; s < 3; s++) add_beat(1, mk(1, 16'h30 + s), 1'b1);
        for (int s = 0; s < 2; s++) add_beat(3, mk(3, 16'h30 + s), 1'b1);
        for (int s = 0; s < 3; s++) exp_q.push_back(mk(1, 16'h30 + s));
        for (int s = 0; s < 2; s++) exp_q.push_back(mk(3, 16'h30 + s));
        drive();
        drain("t3", 60);
        arb_mode = 1'b0;

        // Forced re-arbitration: ch2 streams with no last (24 beats = three full bursts),
        // ch0 joins after ch2 is granted and must slot in after ch2's first 8 beats.
        for (int s = 0; s < 24; s++) add_beat(2, mk(2, s), 1'b0);
        for (int s = 0; s < 8; s++) exp_q.push_back(mk(2, s));
        exp_q.push_back(mk(0, 16'h40));
        for (int s = 8; s < 24; s++) exp_q.push_back(mk(2, s));
        drive();
        cycle();
        cycle();
        check("t4_ch2_granted", 64'(grant_ch), 64'(2));
        add_beat(0, mk(0, 16'h40), 1'b1);
        drive();
        drain("t4", 200);

        // Backpressure: afull for 5 cycles mid-burst, data must arrive in order.
        for (int s = 0; s < 10; s++) begin
            add_beat(1, 32'hA5A5_0000 + 32'(s), s == 9);
            exp_q.push_back(32'hA5A5_0000 + 32'(s));
        end
        drive();
        acc_total = 0;
        n = 0;
        while (acc_total < 3 && n < 50) begin
            cycle();
            n++;
        end
        check("t5_three_accepts", 64'(acc_total), 64'(3));
        acc_before = acc_total;
        fifo_afull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t5_ready_low", 64'(ch_ready), 64'(0));
            cycle();
            check("t5_no_accept", 64'(last_acc), 64'(0));
            check("t5_busy_hold", 64'(busy), 64'(1));
        end
        check("t5_accepts_frozen", 64'(acc_total), 64'(acc_before));
        fifo_afull = 1'b0;
        drain("t5", 80);

`ifdef WR_ARB_STATS_EN
        // Statistics from a clean reset: 3 grants to ch1, 4 stall cycles.
        sys_rst_n = 1'b0;
        clear_bench();
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            add_beat(1, mk(1, 16'h60 + s), 1'b1);
            exp_q.push_back(mk(1, 16'h60 + s));
        end
        drive();
        n = 0;
        while (!busy && n < 20) begin
            cycle();
            n++;
        end
        check("t6_busy_seen", 64'(busy), 64'(1));
        fifo_afull = 1'b1;
        repeat (4) cycle();
        fifo_afull = 1'b0;
        drain("t6", 60);
        check("t6_grants_ch0", 64'(stat_grants[0*16 +: 16]), 64'(0));
        check("t6_grants_ch1", 64'(stat_grants[1*16 +: 16]), 64'(3));
        check("t6_grants_ch2", 64'(stat_grants[2*16 +: 16]), 64'(0));
        check("t6_grants_ch3", 64'(stat_grants[3*16 +: 16]), 64'(0));
        check("t6_stalls",     64'(stat_stall_cycles),       64'(4));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
